// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core that runs one round per clock. Out_valid is asserted 10 clocks after start is accepted.
// It has no backpressure: ready drops for the block, a start while busy is dropped, and the ciphertext is held until the next block completes.

module aes_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the MSBs, so entry i starts at bit 8*(255-i).
   assign out_o = SBOX[{~in_i, 3'b000} +: 8];
endmodule

module aes_encrypt_core #(
   parameter int NR = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [128*(NR+1)-1:0]   round_keys,
   input  logic                    keys_valid,
   input  logic                    start,
   input  logic [127:0]            plaintext,
   output logic                    ready,
   output logic                    out_valid,
   output logic [127:0]            ciphertext,
   output logic [3:0]              busy_round
);
   localparam logic [3:0] LAST_RND = 4'(NR);

   if (NR != 10) begin : g_bad_nr
      $error("aes_encrypt_core supports only NR = 10");
   end

   typedef enum logic {IDLE, RUN} fsm_e;

   fsm_e         fsm_q, fsm_d;
   logic [127:0] state_q, state_d;
   logic [127:0] ct_q, ct_d;
   logic [3:0]   round_q, round_d;
   logic         ready_q, ready_d;
   logic         ov_q, ov_d;

   logic [127:0] sb, sr, mc, rk;

   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   for (genvar i = 0; i < 16; i++) begin : g_sub
      aes_sbox u_sbox (
         .in_i  (state_q[8*i +: 8]),
         .out_o (sb[8*i +: 8])
      );
   end

   // Row r of column c takes the byte from column (c + r) mod 4.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign sr[8*(4*c+r) +: 8] = sb[8*(4*((c+r)%4)+r) +: 8];
      end

      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr[8*(4*c)   +: 8];
      assign a1 = sr[8*(4*c+1) +: 8];
      assign a2 = sr[8*(4*c+2) +: 8];
      assign a3 = sr[8*(4*c+3) +: 8];

      assign mc[8*(4*c)   +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc[8*(4*c+3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
   end

   assign rk = round_keys[{round_q, 7'd0} +: 128];

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      ct_d    = ct_q;
      round_d = round_q;
      ready_d = ready_q;
      ov_d    = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (start && ready_q && keys_valid) begin
               state_d = plaintext ^ round_keys[127:0];
               round_d = 4'd1;
               ready_d = 1'b0;
               fsm_d   = RUN;
            end
         end
         RUN: begin
            // The final round skips MixColumns and writes straight to the output register.
            if (round_q == LAST_RND) begin
               ct_d    = sr ^ rk;
               ov_d    = 1'b1;
               ready_d = 1'b1;
               round_d = 4'd0;
               fsm_d   = IDLE;
            end else begin
               state_d = mc ^ rk;
               round_d = round_q + 4'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         ct_q    <= '0;
         round_q <= '0;
         ready_q <= 1'b1;
         ov_q    <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         ct_q    <= ct_d;
         round_q <= round_d;
         ready_q <= ready_d;
         ov_q    <= ov_d;
      end
   end

   assign ready      = ready_q;
   assign out_valid  = ov_q;
   assign ciphertext = ct_q;
   assign busy_round = round_q;
endmodule

// File: tb/tb_aes_encrypt_core.sv
// Directed bench for aes_encrypt_core using the FIPS-197 C.1 and Appendix B vectors.
// The key schedules are built locally from an S-box derived from the GF(2^8) inverse.

module tb_aes_encrypt_core;
   localparam logic [127:0] K_C1  = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] PT_C1 = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] CT_C1 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
   localparam logic [127:0] K_B   = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
   localparam logic [127:0] PT_B  = 128'h340737e0a29831318d305a88a8f64332;
   localparam logic [127:0] CT_B  = 128'h320b6a19978511dcfb09dc021d842539;

   logic            clk = 1'b0;
   logic            rst;
   logic [1407:0]   round_keys;
   logic            keys_valid;
   logic            start;
   logic [127:0]    plaintext;
   logic            ready;
   logic            out_valid;
   logic [127:0]    ciphertext;
   logic [3:0]      busy_round;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]    sb_tab [256];
   logic [1407:0] rk_c1, rk_b;

   always #5 clk = ~clk;

   aes_encrypt_core #(.NR(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .round_keys (round_keys),
      .keys_valid (keys_valid),
      .start      (start),
      .plaintext  (plaintext),
      .ready      (ready),
      .out_valid  (out_valid),
      .ciphertext (ciphertext),
      .busy_round (busy_round)
   );

   function automatic logic [7:0] xt(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_sbox;
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [1407:0] expand_key(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1407:0] r;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[7:0], t[31:8]};
            t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
            t[7:0] = t[7:0] ^ rc;
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) r[32*i +: 32] = w[i];
      return r;
   endfunction

   // Called at a falling edge; returns at the falling edge right after the accepting edge.
   task automatic start_block(input logic [127:0] pt, input logic [1407:0] rks);
      round_keys = rks;
      plaintext  = pt;
      keys_valid = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int lo);
      lat = 0;
      lo  = 0;
      while (out_valid !== 1'b1 && lat < 30) begin
         if (ready === 1'b0) lo++;
         @(negedge clk);
         lat++;
      end
      if (out_valid !== 1'b1) lat = -1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #1;
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (ciphertext !== 128'h0) begin n_err++; $display("FAIL reset_ciphertext: got %h expected 0", ciphertext); end
      n_vec++; if (busy_round !== 4'd0) begin n_err++; $display("FAIL reset_busy_round: got %0d expected 0", busy_round); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_c1;
      int lat, lo;
      start_block(PT_C1, rk_c1);
      n_vec++; if (busy_round !== 4'd1) begin n_err++; $display("FAIL c1_round1: got %0d expected 1", busy_round); end
      wait_done(lat, lo);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL c1_latency: got %0d expected 10", lat); end
      n_vec++; if (ciphertext !== CT_C1) begin n_err++; $display("FAIL c1_ciphertext: got %h expected %h", ciphertext, CT_C1); end
      n_vec++; if (lo !== 10) begin n_err++; $display("FAIL c1_ready_low: got %0d expected 10", lo); end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL c1_pulse_width: got %b expected 0", out_valid); end
      n_vec++; if (ciphertext !== CT_C1) begin n_err++; $display("FAIL c1_hold: got %h expected %h", ciphertext, CT_C1); end
      n_vec++; if (busy_round !== 4'd0) begin n_err++; $display("FAIL c1_idle_round: got %0d expected 0", busy_round); end
   endtask

   task automatic test_appb;
      int lat, lo;
      start_block(PT_B, rk_b);
      wait_done(lat, lo);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL appb_latency: got %0d expected 10", lat); end
      n_vec++; if (ciphertext !== CT_B) begin n_err++; $display("FAIL appb_ciphertext: got %h expected %h", ciphertext, CT_B); end
      @(negedge clk);
   endtask

   task automatic test_keys_invalid;
      int lat, lo;
      round_keys = rk_c1;
      plaintext  = PT_C1;
      keys_valid = 1'b0;
      start      = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_vec++; if (ready !== 1'b1 || out_valid !== 1'b0 || busy_round !== 4'd0) begin
            n_err++; $display("FAIL nokey_idle[%0d]: got ready=%b ov=%b round=%0d expected 1 0 0", k, ready, out_valid, busy_round);
         end
      end
      keys_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_vec++; if (ready !== 1'b0 || busy_round !== 4'd1) begin
         n_err++; $display("FAIL nokey_accept: got ready=%b round=%0d expected 0 1", ready, busy_round);
      end
      wait_done(lat, lo);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL nokey_latency: got %0d expected 10", lat); end
      n_vec++; if (ciphertext !== CT_C1) begin n_err++; $display("FAIL nokey_ciphertext: got %h expected %h", ciphertext, CT_C1); end
      @(negedge clk);
   endtask

   task automatic test_ignored_start;
      int pulses, pos;
      logic [127:0] cap;
      pulses = 0;
      pos    = -1;
      cap    = '0;
      start_block(PT_C1, rk_c1);
      plaintext = PT_B;
      for (int k = 0; k < 15; k++) begin
         if (out_valid === 1'b1) begin
            pulses++;
            pos = k;
            cap = ciphertext;
         end
         start = (k == 2 || k == 5);
         @(negedge clk);
      end
      start = 1'b0;
      n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
      n_vec++; if (pos !== 10) begin n_err++; $display("FAIL ignore_position: got %0d expected 10", pos); end
      n_vec++; if (cap !== CT_C1) begin n_err++; $display("FAIL ignore_ciphertext: got %h expected %h", cap, CT_C1); end
   endtask

   task automatic test_back_to_back;
      int lat, lo;
      start_block(PT_C1, rk_c1);
      wait_done(lat, lo);
      n_vec++; if (ciphertext !== CT_C1 || lat !== 10) begin
         n_err++; $display("FAIL b2b_first: got %h lat %0d expected %h lat 10", ciphertext, lat, CT_C1);
      end
      start_block(PT_B, rk_b);
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept: got ready=%b expected 0", ready); end
      wait_done(lat, lo);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL b2b_latency: got %0d expected 10", lat); end
      n_vec++; if (ciphertext !== CT_B) begin n_err++; $display("FAIL b2b_ciphertext: got %h expected %h", ciphertext, CT_B); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int lat, lo, pulses;
      start_block(PT_C1, rk_c1);
      repeat (4) @(negedge clk);
      n_vec++; if (busy_round !== 4'd5) begin n_err++; $display("FAIL rstmid_round: got %0d expected 5", busy_round); end
      #2 rst = 1'b1;
      #1;
      n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b expected 1", ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (ciphertext !== 128'h0) begin n_err++; $display("FAIL rstmid_ciphertext: got %h expected 0", ciphertext); end
      n_vec++; if (busy_round !== 4'd0) begin n_err++; $display("FAIL rstmid_busy_round: got %0d expected 0", busy_round); end
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (out_valid === 1'b1) pulses++;
      end
      n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL rstmid_aborted: got %0d pulses expected 0", pulses); end
      start_block(PT_C1, rk_c1);
      wait_done(lat, lo);
      n_vec++; if (lat !== 10 || ciphertext !== CT_C1) begin
         n_err++; $display("FAIL rstmid_fresh: got %h lat %0d expected %h lat 10", ciphertext, lat, CT_C1);
      end
      @(negedge clk);
   endtask

   task automatic test_pt_scramble;
      int lat;
      start_block(PT_C1, rk_c1);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 30) begin
         plaintext = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         lat++;
      end
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL scramble_latency: got %0d expected 10", lat); end
      n_vec++; if (ciphertext !== CT_C1) begin n_err++; $display("FAIL scramble_ciphertext: got %h expected %h", ciphertext, CT_C1); end
      @(negedge clk);
   endtask

   initial begin
      rst        = 1'b1;
      round_keys = '0;
      keys_valid = 1'b0;
      start      = 1'b0;
      plaintext  = '0;
      build_sbox();
      rk_c1 = expand_key(K_C1);
      rk_b  = expand_key(K_B);
      @(negedge clk);
      test_reset();
      test_c1();
      test_appb();
      test_keys_invalid();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      test_pt_scramble();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
